// File: rtl/bank_mem_resp.sv
// Four-bank interleaved word memory responding to cache fill/evict requests.
// Each bank is occupied for BANK_CYC cycles per access; read data returns 2 cycles after accept.
module bank_mem_resp #(
  parameter int ADDR_W   = 16,
  parameter int DEPTH_W  = 13,
  parameter int BANK_CYC = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] addr,
  input  logic [15:0]       data_in,
  input  logic              wr,
  input  logic              rd,
  output logic [15:0]       data_out,
  output logic              data_vld,
  output logic              stall,
  output logic [3:0]        busy,
  output logic              err
);

  localparam int CW = (BANK_CYC > 2) ? $clog2(BANK_CYC) : 1;
  localparam logic [CW-1:0] CNT_INIT = CW'(BANK_CYC - 1);

  logic               req;
  logic               bad;
  logic               acc;
  logic [1:0]         b;
  logic [DEPTH_W-1:0] row;
  logic [DEPTH_W+1:0] idx;

  logic [CW-1:0] cnt_q [4];
  logic [CW-1:0] cnt_d [4];
  logic [3:0]    busy_w;

  logic [15:0] mem_q [4*(2**DEPTH_W)];
  logic [15:0] s1_data_q;
  logic        s1_v_q;
  logic [15:0] dout_q;
  logic        vld_q;
  logic        err_q;

  assign b     = addr[2:1];
  assign row   = addr[DEPTH_W+2:3];
  assign idx   = {row, b};
  assign req   = rd | wr;
  assign bad   = (rd & wr) | addr[0];
  assign acc   = req & ~bad & ~busy_w[b];
  assign stall = req & ~bad & busy_w[b];

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      busy_w[i] = (cnt_q[i] != '0);
      cnt_d[i]  = cnt_q[i];
      if (acc && (b == 2'(i))) begin
        cnt_d[i] = CNT_INIT;
      end else if (cnt_q[i] != '0) begin
        cnt_d[i] = cnt_q[i] - CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) cnt_q[i] <= '0;
      s1_v_q <= 1'b0;
      vld_q  <= 1'b0;
      dout_q <= 16'h0000;
      err_q  <= 1'b0;
    end else begin
      for (int i = 0; i < 4; i++) cnt_q[i] <= cnt_d[i];
      s1_v_q <= acc & rd;
      vld_q  <= s1_v_q;
      if (s1_v_q) dout_q <= s1_data_q;
      err_q  <= req & bad;
    end
  end

  // Array and read staging register carry no reset so they map onto RAM.
  always_ff @(posedge clk) begin
    if (acc && wr) mem_q[idx] <= data_in;
    if (acc && rd) s1_data_q <= mem_q[idx];
  end

  assign busy     = busy_w;
  assign data_out = dout_q;
  assign data_vld = vld_q;
  assign err      = err_q;

endmodule

// File: tb/tb_bank_mem_resp.sv
// Table-driven bench for bank_mem_resp with a read-data scoreboard.
// Each table row is one clock cycle of stimulus plus expected stall/busy.
module tb_bank_mem_resp;

  logic        clk;
  logic        rst_n;
  logic [15:0] addr;
  logic [15:0] data_in;
  logic        wr;
  logic        rd;
  logic [15:0] data_out;
  logic        data_vld;
  logic        stall;
  logic [3:0]  busy;
  logic        err;

  bank_mem_resp dut (
    .clk(clk), .rst_n(rst_n), .addr(addr), .data_in(data_in),
    .wr(wr), .rd(rd), .data_out(data_out), .data_vld(data_vld),
    .stall(stall), .busy(busy), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [15:0] addr;
    logic [15:0] din;
    logic        st;
    logic [3:0]  bz;
  } vec_t;

  typedef struct {
    int          due;
    logic [15:0] data;
  } exp_t;

  vec_t        tbl [38];
  exp_t        q [$];
  logic [15:0] mdl [int];
  int          nvec = 0;
  int          nerr = 0;
  int          cyc  = 0;
  logic        prev_bad = 1'b0;

  function automatic vec_t V(logic r, logic w, logic [15:0] a,
                             logic [15:0] d, logic s, logic [3:0] bz);
    vec_t v;
    v.rd = r; v.wr = w; v.addr = a; v.din = d; v.st = s; v.bz = bz;
    return v;
  endfunction

  task automatic chk(string nm, logic [15:0] act, logic [15:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc, act, exp);
    end
  endtask

  task automatic step(vec_t v);
    logic req, bad, acc;
    exp_t e;
    rd = v.rd; wr = v.wr; addr = v.addr; data_in = v.din;
    req = v.rd | v.wr;
    bad = (v.rd & v.wr) | v.addr[0];
    acc = rst_n & req & ~bad & ~v.st;
    @(negedge clk);
    chk("stall", {15'b0, stall}, {15'b0, v.st});
    chk("busy", {12'b0, busy}, {12'b0, v.bz});
    chk("err", {15'b0, err}, {15'b0, prev_bad});
    if (q.size() > 0 && q[0].due == cyc) begin
      e = q.pop_front();
      chk("vld", {15'b0, data_vld}, 16'h0001);
      chk("dout", data_out, e.data);
    end else begin
      chk("novld", {15'b0, data_vld}, 16'h0000);
    end
    if (!rst_n) chk("dout_rst", data_out, 16'h0000);
    if (acc && v.wr) mdl[int'(v.addr[15:1])] = v.din;
    if (acc && v.rd) begin
      e.due  = cyc + 2;
      e.data = mdl[int'(v.addr[15:1])];
      q.push_back(e);
    end
    prev_bad = rst_n & req & bad;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  initial begin
    tbl[0]  = V(0, 1, 16'h0018, 16'h5A5A, 0, 4'b0000);
    tbl[1]  = V(0, 1, 16'h0012, 16'h1234, 0, 4'b0001);
    tbl[2]  = V(0, 0, 16'h0000, 16'h0000, 0, 4'b0011);
    tbl[3]  = V(0, 0, 16'h0000, 16'h0000, 0, 4'b0011);
    tbl[4]  = V(0, 1, 16'h0010, 16'hBEEF, 0, 4'b0010);
    tbl[5]  = V(0, 0, 16'h0000, 16'h0000, 0, 4'b0001);
    tbl[6]  = V(0, 0, 16'h0000, 16'h0000, 0, 4'b0001);
    tbl[7]  = V(0, 0, 16'h0000, 16'h0000, 0, 4'b0001);
    tbl[8]  = V(1, 0, 16'h0010, 16'h0000, 0, 4'b0000);
    tbl[9]  = V(1, 0, 16'h0012, 16'h0000, 0, 4'b0001);
    tbl[10] = V(1, 0, 16'h0018, 16'h0000, 1, 4'b0011);
    tbl[11] = V(1, 0, 16'h0018, 16'h0000, 1, 4'b0011);
    tbl[12] = V(1, 0, 16'h0018, 16'h0000, 0, 4'b0010);
    tbl[13] = V(1, 1, 16'h0012, 16'hDEAD, 0, 4'b0001);
    tbl[14] = V(1, 0, 16'h0011, 16'h0000, 0, 4'b0001);
    tbl[15] = V(0, 0, 16'h0000, 16'h0000, 0, 4'b0001);
    tbl[16] = V(0, 0, 16'h0000, 16'h0000, 0, 4'b0000);
    tbl[17] = V(1, 0, 16'h0012, 16'h0000, 0, 4'b0000);
    tbl[18] = V(0, 0, 16'h0000, 16'h0000, 0, 4'b0010);
    tbl[19] = V(0, 0, 16'h0000, 16'h0000, 0, 4'b0010);
    tbl[20] = V(0, 0, 16'h0000, 16'h0000, 0, 4'b0010);
    tbl[21] = V(0, 1, 16'h0100, 16'h1111, 0, 4'b0000);
    tbl[22] = V(0, 1, 16'h0102, 16'h2222, 0, 4'b0001);
    tbl[23] = V(0, 1, 16'h0104, 16'h3333, 0, 4'b0011);
    tbl[24] = V(0, 1, 16'h0106, 16'h4444, 0, 4'b0111);
    tbl[25] = V(1, 0, 16'h0100, 16'h0000, 0, 4'b1110);
    tbl[26] = V(0, 0, 16'h0000, 16'h0000, 0, 4'b1101);
    tbl[27] = V(0, 0, 16'h0000, 16'h0000, 0, 4'b1001);
    tbl[28] = V(0, 0, 16'h0000, 16'h0000, 0, 4'b0001);
    tbl[29] = V(0, 1, 16'hFFFE, 16'hCAFE, 0, 4'b0000);
    tbl[30] = V(0, 0, 16'h0000, 16'h0000, 0, 4'b1000);
    tbl[31] = V(0, 0, 16'h0000, 16'h0000, 0, 4'b1000);
    tbl[32] = V(0, 0, 16'h0000, 16'h0000, 0, 4'b1000);
    tbl[33] = V(1, 0, 16'hFFFE, 16'h0000, 0, 4'b0000);
    tbl[34] = V(0, 0, 16'h0000, 16'h0000, 0, 4'b1000);
    tbl[35] = V(0, 0, 16'h0000, 16'h0000, 0, 4'b1000);
    tbl[36] = V(0, 0, 16'h0000, 16'h0000, 0, 4'b1000);
    tbl[37] = V(0, 0, 16'h0000, 16'h0000, 0, 4'b0000);

    rst_n = 1'b0; rd = 1'b1; wr = 1'b0;
    addr = 16'h0010; data_in = 16'h0000;
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++)
      step(V(1, 0, 16'h0010, 16'h0000, 0, 4'b0000));
    rst_n = 1'b1;

    foreach (tbl[i]) step(tbl[i]);

    // Fill burst, a read left in flight, then a reset that must drop it.
    step(V(0, 1, 16'h0100, 16'hA001, 0, 4'b0000));
    step(V(0, 1, 16'h0102, 16'hA002, 0, 4'b0001));
    step(V(0, 1, 16'h0104, 16'hA003, 0, 4'b0011));
    step(V(0, 1, 16'h0106, 16'hA004, 0, 4'b0111));
    step(V(1, 0, 16'h0100, 16'h0000, 0, 4'b1110));
    rst_n = 1'b0;
    q.delete();
    step(V(1, 0, 16'h0102, 16'h0000, 0, 4'b0000));
    step(V(1, 0, 16'h0102, 16'h0000, 0, 4'b0000));
    rst_n = 1'b1;
    step(V(1, 0, 16'h0100, 16'h0000, 0, 4'b0000));
    step(V(1, 0, 16'h0102, 16'h0000, 0, 4'b0001));
    step(V(1, 0, 16'h0104, 16'h0000, 0, 4'b0011));
    step(V(1, 0, 16'h0106, 16'h0000, 0, 4'b0111));
    step(V(0, 0, 16'h0000, 16'h0000, 0, 4'b1110));
    step(V(0, 0, 16'h0000, 16'h0000, 0, 4'b1100));
    step(V(0, 0, 16'h0000, 16'h0000, 0, 4'b1000));
    step(V(0, 0, 16'h0000, 16'h0000, 0, 4'b0000));
    chk("drain", 16'(q.size()), 16'h0000);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
